instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
- Upstream fetch/decode/sequencing stage for the 8-bit ALU datapath.
- Holds a small writable program memory, a program counter and a 4x8 operand register file.
- Each cycle it drives opcode/a/b into the ALU stage and writes the ALU result back into the register file.
- Runs a program from address 0 to HALT under a start/busy/done handshake.

Parameters:
- ADDR_W, 4, program-memory address width (depth 2^ADDR_W words of 16 bits).

Ports:
- clk  in  1  clock.
- reset  in  1  reset; synchronous, active-low.
- start  in  1  pulse; begins execution at PC=0 when idle/halted.
- busy  out  1  high while the program runs.
- done  out  1  one-cycle pulse on entry to HALTED.
- wrap_err  out  1  sticky; PC wrapped without HALT; cleared by start or reset.
- prog_we  in  1  program-memory write strobe.
- prog_addr  in  ADDR_W  program-memory write address.
- prog_data  in  16  instruction word to store.
- opcode  out  3  ALU operation select to the ALU stage.
- a  out  8  ALU operand A.
- b  out  8  ALU operand B.
- alu_result  in  8  combinational ALU result.
- alu_carry  in  1  combinational ALU carry/flag.
- carry_flag  out  1  carry captured at the last ALU writeback.
- pc  out  ADDR_W  current program counter.
- dbg_sel  in  2  register-file observation select.
- dbg_data  out  8  combinational read of reg[dbg_sel].

Behaviour:
- Instruction format, bit15=0 (ALU op):
  - [14:12] opcode
  - [11:10] rd
  - [9:8] rs1
  - [7:6] rs2
  - [5:0] ignored
- Instruction format, bit15=1, bit14=0 (LDI): [11:10] rd, [7:0] imm8.
- Instruction format, bit15=1, bit14=1: HALT.
- ALU opcode encoding: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 mul, 110 div, 111 eq.
- Program memory: registered read (1-cycle latency). Not cleared by reset; contents persist across reset.
- prog_we is honoured only in IDLE/HALTED and ignored while busy.
- FSM states: IDLE, FETCH, DECODE, EXEC, WB, HALTED.
  - IDLE/HALTED + start -> FETCH. Same edge: pc=0, wrap_err=0, busy=1.
  - FETCH -> DECODE. Memory read of mem[pc] is issued.
  - DECODE -> instr latched, then:
    - ALU op -> EXEC.
    - LDI -> WB.
    - HALT -> HALTED.
  - EXEC: opcode=instr[14:12], a=reg[rs1], b=reg[rs2]; all three held stable for this cycle and through WB. -> WB.
  - WB, ALU op: reg[rd]<=alu_result and carry_flag<=alu_carry.
  - WB, LDI: reg[rd]<=imm8; carry_flag unchanged.
  - WB: pc<=pc+1 (mod 2^ADDR_W). If pc was 2^ADDR_W-1, set wrap_err and go to HALTED; otherwise go to FETCH.
  - Entry to HALTED: busy=0, done=1 for one cycle. pc holds the HALT address (or 0 after a wrap).
- Cycles per instruction: ALU op 4, LDI 3, HALT 2 (FETCH+DECODE).
- start while busy: ignored. start in HALTED: restarts from PC=0; register file is not cleared.
- rd equal to rs1/rs2 is legal: operands are read in EXEC and the write happens in WB.
- Outside EXEC/WB: opcode=000, a=0, b=0.
- Reset values (applied at the posedge with reset=0, including mid-program):
  - state=IDLE
  - pc=0, busy=0, done=0, wrap_err=0
  - carry_flag=0
  - opcode=0, a=0, b=0
  - all registers=0
- All arithmetic is 8-bit, done by the ALU stage. This block performs no arithmetic except the PC increment.

Decomposition:
- Shared package `seq_pkg` contains:
  - state enum
  - opcode constants (OP_ADD..OP_EQ)
  - field bit positions
  - constants for the instruction-class bits [15:14]
- One sub-module: `prog_mem` — 2^ADDR_W x 16 memory, sync write, registered read.

Test Plan:
- Load LDI r0,5; LDI r1,3; ALU add r2,r0,r1; HALT; then start -> r2=0x08, carry_flag=0, done pulses 12 cycles after start (3+3+4+2), busy low afterwards.
- LDI r0,3; LDI r1,5; sub r2,r0,r1; HALT -> opcode=001 with a=3, b=5 during EXEC; r2=0xFE; carry_flag reflects alu_carry=1 from the ALU model.
- div r3,r0,r1 with r1=0 -> r3=0x00, carry_flag=1; then and r3,r0,r0 with r0=0xF0 -> r3=0xF0, carry_flag=0.
- Memory full of ALU ops with no HALT -> after 16 instructions: wrap_err=1, done pulse, pc=0. A new start clears wrap_err.
- start pulsed mid-run and prog_we asserted while busy -> both ignored; program result and memory contents unchanged.
- reset=0 during EXEC -> next cycle: IDLE, busy=0, registers=0, pc=0. Restart runs the still-loaded program correctly.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the instruction sequencer: FSM states, ALU opcodes and
// instruction field positions.
package seq_pkg;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StFetch  = 3'd1;
  localparam logic [2:0] StDecode = 3'd2;
  localparam logic [2:0] StExec   = 3'd3;
  localparam logic [2:0] StWb     = 3'd4;
  localparam logic [2:0] StHalted = 3'd5;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_DIV = 3'b110;
  localparam logic [2:0] OP_EQ  = 3'b111;

  localparam int unsigned ClassMsb  = 15;
  localparam int unsigned ClassLsb  = 14;
  localparam int unsigned OpcodeMsb = 14;
  localparam int unsigned OpcodeLsb = 12;
  localparam int unsigned RdMsb     = 11;
  localparam int unsigned RdLsb     = 10;
  localparam int unsigned Rs1Msb    = 9;
  localparam int unsigned Rs1Lsb    = 8;
  localparam int unsigned Rs2Msb    = 7;
  localparam int unsigned Rs2Lsb    = 6;
  localparam int unsigned ImmMsb    = 7;
  localparam int unsigned ImmLsb    = 0;

  // Values of instr[15:14]; bit 15 clear means an ALU op regardless of bit 14.
  localparam logic [1:0] ClassLdi  = 2'b10;
  localparam logic [1:0] ClassHalt = 2'b11;

endpackage

// File: rtl/prog_mem.sv
// Program memory: 2^ADDR_W x 16, synchronous write, registered read. Contents are
// deliberately not reset so a loaded program survives a reset.
module prog_mem #(
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [15:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [15:0]       rdata
);

  localparam int unsigned Depth = 1 << ADDR_W;

  logic [15:0] mem_q [Depth];
  logic [15:0] rdata_d, rdata_q;

  always_comb begin
    rdata_d = mem_q[raddr];
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/sequencing stage for the 8-bit ALU: runs a stored program from
// address 0 to HALT, feeding operands to the ALU and writing results back.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              wrap_err,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [15:0]       prog_data,
  output logic [2:0]        opcode,
  output logic [7:0]        a,
  output logic [7:0]        b,
  input  logic [7:0]        alu_result,
  input  logic              alu_carry,
  output logic              carry_flag,
  output logic [ADDR_W-1:0] pc,
  input  logic [1:0]        dbg_sel,
  output logic [7:0]        dbg_data
);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              wrap_q, wrap_d;
  logic              carry_q, carry_d;
  logic [2:0]        op_q, op_d;
  logic [7:0]        a_q, a_d;
  logic [7:0]        b_q, b_d;
  // Only the fields needed at writeback are kept past DECODE.
  logic              wb_alu_q, wb_alu_d;
  logic [1:0]        wb_rd_q, wb_rd_d;
  logic [7:0]        wb_imm_q, wb_imm_d;
  logic [7:0]        regs_q [4];
  logic [7:0]        regs_d [4];

  logic              idle_like;
  logic [15:0]       mem_rdata;

  assign idle_like = (state_q == StIdle) || (state_q == StHalted);

  prog_mem #(
    .ADDR_W(ADDR_W)
  ) u_prog_mem (
    .clk  (clk),
    .we   (prog_we && idle_like),
    .waddr(prog_addr),
    .wdata(prog_data),
    .raddr(pc_q),
    .rdata(mem_rdata)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    wrap_d   = wrap_q;
    carry_d  = carry_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    wb_alu_d = wb_alu_q;
    wb_rd_d  = wb_rd_q;
    wb_imm_d = wb_imm_q;
    regs_d   = regs_q;

    unique case (state_q)
      StIdle, StHalted: begin
        if (start) begin
          state_d = StFetch;
          pc_d    = '0;
          wrap_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      StFetch: state_d = StDecode;
      StDecode: begin
        wb_alu_d = ~mem_rdata[ClassMsb];
        wb_rd_d  = mem_rdata[RdMsb:RdLsb];
        wb_imm_d = mem_rdata[ImmMsb:ImmLsb];
        if (!mem_rdata[ClassMsb]) begin
          state_d = StExec;
          op_d    = mem_rdata[OpcodeMsb:OpcodeLsb];
          a_d     = regs_q[mem_rdata[Rs1Msb:Rs1Lsb]];
          b_d     = regs_q[mem_rdata[Rs2Msb:Rs2Lsb]];
        end else if (mem_rdata[ClassMsb:ClassLsb] == ClassLdi) begin
          state_d = StWb;
        end else begin
          state_d = StHalted;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      StExec: state_d = StWb;
      StWb: begin
        if (wb_alu_q) begin
          regs_d[wb_rd_q] = alu_result;
          carry_d         = alu_carry;
        end else begin
          regs_d[wb_rd_q] = wb_imm_q;
        end
        op_d = OP_ADD;
        a_d  = '0;
        b_d  = '0;
        pc_d = pc_q + ADDR_W'(1);
        if (pc_q == '1) begin
          state_d = StHalted;
          wrap_d  = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = StFetch;
        end
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= StIdle;
      pc_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wrap_q   <= 1'b0;
      carry_q  <= 1'b0;
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      wb_alu_q <= 1'b0;
      wb_rd_q  <= '0;
      wb_imm_q <= '0;
      for (int i = 0; i < 4; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      wrap_q   <= wrap_d;
      carry_q  <= carry_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      wb_alu_q <= wb_alu_d;
      wb_rd_q  <= wb_rd_d;
      wb_imm_q <= wb_imm_d;
      regs_q   <= regs_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign wrap_err   = wrap_q;
  assign carry_flag = carry_q;
  assign opcode     = op_q;
  assign a          = a_q;
  assign b          = b_q;
  assign pc         = pc_q;
  assign dbg_data   = regs_q[dbg_sel];

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer with a behavioural ALU stage in the loop.
module tb_instr_sequencer;
  import seq_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       busy, done, wrap_err;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [15:0] prog_data;
  logic [2:0] opcode;
  logic [7:0] a, b;
  logic [7:0] alu_result;
  logic       alu_carry;
  logic       carry_flag;
  logic [3:0] pc;
  logic [1:0] dbg_sel;
  logic [7:0] dbg_data;

  int errors = 0;
  int checks = 0;

  logic [2:0] hist_op   [256];
  logic [7:0] hist_a    [256];
  logic [7:0] hist_b    [256];
  logic       hist_busy [256];
  logic       hist_wrap [256];
  int         done_cyc;

  always #5 clk = ~clk;

  instr_sequencer #(
    .ADDR_W(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .wrap_err  (wrap_err),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .opcode    (opcode),
    .a         (a),
    .b         (b),
    .alu_result(alu_result),
    .alu_carry (alu_carry),
    .carry_flag(carry_flag),
    .pc        (pc),
    .dbg_sel   (dbg_sel),
    .dbg_data  (dbg_data)
  );

  // ALU stage model; sub sets carry on borrow, div-by-zero gives 0 with carry set.
  always_comb begin
    logic [15:0] t;
    t          = '0;
    alu_result = '0;
    alu_carry  = 1'b0;
    case (opcode)
      OP_ADD: begin t = {8'd0, a} + {8'd0, b}; alu_result = t[7:0]; alu_carry = t[8]; end
      OP_SUB: begin alu_result = a - b; alu_carry = (a < b); end
      OP_AND: alu_result = a & b;
      OP_OR:  alu_result = a | b;
      OP_XOR: alu_result = a ^ b;
      OP_MUL: begin t = {8'd0, a} * {8'd0, b}; alu_result = t[7:0]; alu_carry = |t[15:8]; end
      OP_DIV: begin
        if (b == 8'd0) begin alu_result = 8'd0; alu_carry = 1'b1; end
        else alu_result = a / b;
      end
      default: begin alu_result = {7'd0, a == b}; alu_carry = (a == b); end
    endcase
  end

  function automatic logic [15:0] alu_i(input logic [2:0] op, input logic [1:0] rd,
                                        input logic [1:0] rs1, input logic [1:0] rs2);
    return {1'b0, op, rd, rs1, rs2, 6'd0};
  endfunction

  function automatic logic [15:0] ldi_i(input logic [1:0] rd, input logic [7:0] imm);
    return {2'b10, 2'b00, rd, 2'b00, imm};
  endfunction

  localparam logic [15:0] HaltI = 16'hC000;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [3:0] addr, input logic [15:0] data);
    @(negedge clk);
    prog_we   = 1'b1;
    prog_addr = addr;
    prog_data = data;
    @(posedge clk);
    #1;
    prog_we = 1'b0;
  endtask

  task automatic check_reg(input string tag, input logic [1:0] idx, input logic [7:0] exp);
    dbg_sel = idx;
    #1;
    check_eq(tag, {24'd0, dbg_data}, {24'd0, exp});
  endtask

  // Pulses start, then records outputs per cycle until done (bounded). At cycle
  // inj_cyc a start pulse and a program write to address 3 are attempted.
  task automatic run_prog(input int inj_cyc);
    done_cyc = -1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk);
      #1;
      start     = 1'b0;
      prog_we   = 1'b0;
      hist_op[c]   = opcode;
      hist_a[c]    = a;
      hist_b[c]    = b;
      hist_busy[c] = busy;
      hist_wrap[c] = wrap_err;
      if (done) begin
        done_cyc = c;
        break;
      end
      if (c == inj_cyc) begin
        start     = 1'b1;
        prog_we   = 1'b1;
        prog_addr = 4'd3;
        prog_data = ldi_i(2'd2, 8'h55);
      end
    end
  endtask

  task automatic check_after_done(input string tag);
    @(posedge clk);
    #1;
    check_eq({tag, "_done_1cyc"}, {31'd0, done}, 32'd0);
    check_eq({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    prog_we   = 1'b0;
    prog_addr = '0;
    prog_data = '0;
    dbg_sel   = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_wrap", {31'd0, wrap_err}, 32'd0);
    check_eq("rst_pc", {28'd0, pc}, 32'd0);
    check_eq("rst_carry", {31'd0, carry_flag}, 32'd0);
    check_eq("rst_opab", {13'd0, opcode, a, b}, 32'd0);
    check_reg("rst_r3", 2'd3, 8'd0);
    reset = 1'b1;

    // add: 5 + 3
    load(4'd0, ldi_i(2'd0, 8'd5));
    load(4'd1, ldi_i(2'd1, 8'd3));
    load(4'd2, alu_i(OP_ADD, 2'd2, 2'd0, 2'd1));
    load(4'd3, HaltI);
    run_prog(-1);
    check_eq("add_done_cyc", done_cyc, 32'd12);
    check_eq("add_busy_c1", {31'd0, hist_busy[1]}, 32'd1);
    check_reg("add_r2", 2'd2, 8'h08);
    check_eq("add_carry", {31'd0, carry_flag}, 32'd0);
    check_eq("add_pc", {28'd0, pc}, 32'd3);
    check_after_done("add");

    // sub: 3 - 5, operands visible through EXEC and WB
    load(4'd0, ldi_i(2'd0, 8'd3));
    load(4'd1, ldi_i(2'd1, 8'd5));
    load(4'd2, alu_i(OP_SUB, 2'd2, 2'd0, 2'd1));
    run_prog(-1);
    check_eq("sub_done_cyc", done_cyc, 32'd12);
    check_eq("sub_exec_opab", {13'd0, hist_op[8], hist_a[8], hist_b[8]}, {13'd0, 3'b001, 8'd3, 8'd5});
    check_eq("sub_wb_opab", {13'd0, hist_op[9], hist_a[9], hist_b[9]}, {13'd0, 3'b001, 8'd3, 8'd5});
    check_eq("sub_fetch_opab", {13'd0, hist_op[10], hist_a[10], hist_b[10]}, 32'd0);
    check_reg("sub_r2", 2'd2, 8'hFE);
    check_eq("sub_carry", {31'd0, carry_flag}, 32'd1);

    // div by zero, then and with rd==rs1==rs2 after restart from HALTED
    load(4'd0, ldi_i(2'd0, 8'hF0));
    load(4'd1, ldi_i(2'd1, 8'h00));
    load(4'd2, alu_i(OP_DIV, 2'd3, 2'd0, 2'd1));
    run_prog(-1);
    check_eq("div_done_cyc", done_cyc, 32'd12);
    check_reg("div_r3", 2'd3, 8'h00);
    check_eq("div_carry", {31'd0, carry_flag}, 32'd1);
    load(4'd2, alu_i(OP_AND, 2'd3, 2'd0, 2'd0));
    run_prog(-1);
    check_eq("and_done_cyc", done_cyc, 32'd12);
    check_reg("and_r3", 2'd3, 8'hF0);
    check_eq("and_carry", {31'd0, carry_flag}, 32'd0);

    // wrap: 16 x add r1,r1,r3 with r1=0, r3=F0 -> r1 back to 0, final carry 1
    for (int i = 0; i < 16; i++) load(4'(i), alu_i(OP_ADD, 2'd1, 2'd1, 2'd3));
    run_prog(-1);
    check_eq("wrap_done_cyc", done_cyc, 32'd64);
    check_eq("wrap_err", {31'd0, wrap_err}, 32'd1);
    check_eq("wrap_pc", {28'd0, pc}, 32'd0);
    check_reg("wrap_r1", 2'd1, 8'h00);
    check_eq("wrap_carry", {31'd0, carry_flag}, 32'd1);
    run_prog(-1);
    check_eq("wrap_clr_on_start", {31'd0, hist_wrap[1]}, 32'd0);
    check_eq("wrap_again", {31'd0, wrap_err}, 32'd1);

    // start and prog_we while busy are ignored
    load(4'd0, ldi_i(2'd0, 8'd5));
    load(4'd1, ldi_i(2'd1, 8'd3));
    load(4'd2, alu_i(OP_ADD, 2'd2, 2'd0, 2'd1));
    load(4'd3, HaltI);
    run_prog(5);
    check_eq("busy_ign_done_cyc", done_cyc, 32'd12);
    check_reg("busy_ign_r2", 2'd2, 8'h08);
    check_eq("busy_ign_pc", {28'd0, pc}, 32'd3);

    // reset during EXEC of the add
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check_eq("pre_rst_ab", {16'd0, a, b}, {16'd0, 8'd5, 8'd3});
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("mid_rst_pc", {28'd0, pc}, 32'd0);
    check_eq("mid_rst_opab", {13'd0, opcode, a, b}, 32'd0);
    check_reg("mid_rst_r0", 2'd0, 8'd0);
    check_reg("mid_rst_r2", 2'd2, 8'd0);
    run_prog(-1);
    check_eq("post_rst_done_cyc", done_cyc, 32'd12);
    check_reg("post_rst_r2", 2'd2, 8'h08);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
